// File: rtl/usb_data_tx_framer.sv
// USB data-packet transmit framer: emits PID, payload and inverted CRC16 (0x8005) bytes.
// Optional payload-length check enabled by defining USB_TX_FRAMER_LEN_CHECK_EN.
`timescale 1ns/1ps
module usb_data_tx_framer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  pid,
    input  logic        zlp,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] crc_out,
    output logic        len_err
);

    typedef enum logic [2:0] {StIdle, StPid, StPayload, StCrcLo, StCrcHi} state_e;

    state_e      state_q, state_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic [15:0] crc_q, crc_d;
    logic        zlp_q, zlp_d;
    logic        lo_loaded_q, lo_loaded_d;
    logic        s_acc, m_acc, out_free;
    logic [15:0] crc_next;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    assign s_ready  = (state_q == StPayload) & (~m_valid_q | m_ready);
    assign busy     = (state_q != StIdle);
    assign s_acc    = s_valid & s_ready;
    assign m_acc    = m_valid_q & m_ready;
    assign out_free = ~m_valid_q | m_ready;
    assign crc_next = crc16_byte(crc_q, s_data);

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign crc_out = crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StPid;
            StPid:     if (m_acc) state_d = zlp_q ? StCrcLo : StPayload;
            StPayload: if (s_acc && s_last) state_d = StCrcLo;
            StCrcLo:   if (lo_loaded_q && m_acc) state_d = StCrcHi;
            StCrcHi:   if (m_acc) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output register next values; the CRC low byte is loaded once the last payload byte drains.
    always_comb begin
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        crc_d       = crc_q;
        zlp_d       = zlp_q;
        lo_loaded_d = lo_loaded_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_data_d    = {~pid, pid};
                    m_valid_d   = 1'b1;
                    m_last_d    = 1'b0;
                    crc_d       = 16'hFFFF;
                    zlp_d       = zlp;
                    lo_loaded_d = 1'b0;
                end
            end
            StPid: begin
                if (m_acc) begin
                    if (zlp_q) begin
                        m_data_d    = ~crc_q[7:0];
                        lo_loaded_d = 1'b1;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end
            end
            StPayload: begin
                if (s_acc) begin
                    m_data_d  = s_data;
                    m_valid_d = 1'b1;
                    crc_d     = crc_next;
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                end
            end
            StCrcLo: begin
                if (!lo_loaded_q) begin
                    if (out_free) begin
                        m_data_d    = ~crc_q[7:0];
                        m_valid_d   = 1'b1;
                        lo_loaded_d = 1'b1;
                    end
                end else if (m_ready) begin
                    m_data_d = ~crc_q[15:8];
                    m_last_d = 1'b1;
                end
            end
            StCrcHi: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q    <= 8'h00;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            crc_q       <= 16'hFFFF;
            zlp_q       <= 1'b0;
            lo_loaded_q <= 1'b0;
        end else begin
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            crc_q       <= crc_d;
            zlp_q       <= zlp_d;
            lo_loaded_q <= lo_loaded_d;
        end
    end

`ifdef USB_TX_FRAMER_LEN_CHECK_EN
    logic [10:0] len_cnt_q, len_cnt_d;
    logic        len_err_q, len_err_d;

    always_comb begin
        len_cnt_d = len_cnt_q;
        len_err_d = len_err_q;
        if (state_q == StIdle && start) begin
            len_cnt_d = 11'd0;
            len_err_d = 1'b0;
        end else if (state_q == StPayload && s_acc) begin
            if (len_cnt_q == 11'd1024) len_err_d = 1'b1;
            // Saturate so a runaway payload cannot wrap back under the limit.
            if (len_cnt_q != 11'h7FF) len_cnt_d = len_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt_q <= 11'd0;
            len_err_q <= 1'b0;
        end else begin
            len_cnt_q <= len_cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: doc/usb_data_tx_framer.md
USB_DATA_TX_FRAMER -- requirements
Module: usb_data_tx_framer

Interface
REQ-001 The block SHALL use one clock and one reset: the clock port is `clk` and the reset is `rst_n`, asynchronous and active-low.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  packet start pulse, sampled only in IDLE
- pid  in  4  packet ID for the packet being started
- zlp  in  1  zero-length packet flag, sampled with start
- s_data  in  8  payload byte
- s_valid  in  1  payload byte valid
- s_last  in  1  marks final payload byte
- s_ready  out  1  payload byte accepted when s_valid & s_ready
- m_data  out  8  framed output byte
- m_valid  out  1  output byte valid
- m_last  out  1  marks final byte of the frame (CRC high byte)
- m_ready  in  1  downstream accepts when m_valid & m_ready
- busy  out  1  high in any state other than IDLE
- crc_out  out  16  running CRC register, not complemented
- len_err  out  1  sticky payload-overlength flag (see REQ-016)

Function
REQ-003 The FSM SHALL have the states IDLE, PID, PAYLOAD, CRC_LO, CRC_HI.
REQ-004 Transitions:
- IDLE->PID on start=1, latching pid and zlp and loading the CRC register with 0xFFFF.
- PID->PAYLOAD when the PID byte is accepted with zlp=0.
- PID->CRC_LO when the PID byte is accepted with zlp=1.
- PAYLOAD->CRC_LO when a byte with s_last=1 is accepted.
- CRC_LO->CRC_HI when the CRC low byte is accepted.
- CRC_HI->IDLE when the CRC high byte is accepted.
REQ-005 The PID byte SHALL be {~pid, pid}, i.e. check nibble in bits [7:4], and SHALL NOT enter the CRC.
REQ-006 CRC arithmetic:
- polynomial x^16+x^15+x^2+1 (0x8005), init 0xFFFF;
- left-shifting LFSR, each byte processed MSB first (data bit 7 first), no reflection;
- one byte per accepted payload beat.
REQ-007 The transmitted CRC SHALL be ~crc_out: low byte (bits [7:0]) first, then high byte, with m_last=1 only on the high byte.
REQ-008 m_data, m_valid and m_last SHALL be registered; payload latency from s_data acceptance to m_data SHALL be 1 cycle.
REQ-009 s_ready SHALL equal (state==PAYLOAD) & (~m_valid | m_ready), and SHALL be 0 in all other states.
REQ-010 While m_valid=1 and m_ready=0, m_data, m_valid and m_last SHALL hold stable.
REQ-011 Full throughput: with s_valid=1 and m_ready=1 held continuously, one byte SHALL move per cycle with no bubbles, including the PAYLOAD->CRC_LO transition.
REQ-012 start asserted while busy=1 SHALL be ignored, with no effect on the current frame.
REQ-013 crc_out SHALL update in the same cycle a payload byte is accepted, SHALL hold otherwise, and SHALL keep its final value in IDLE until the next start.

Reset
REQ-014 While rst_n=0, regardless of clk, the following SHALL hold:
- state = IDLE
- m_valid = 0, m_last = 0, m_data = 0x00
- s_ready = 0, busy = 0
- crc_out = 0xFFFF, len_err = 0
REQ-015 Reset asserted mid-frame SHALL abandon the frame with no further output; the next frame SHALL start cleanly after the next start.

Configuration
REQ-016 Macro USB_TX_FRAMER_LEN_CHECK_EN:
- Defined: an 11-bit payload counter SHALL clear on start.
- Defined: when a payload byte is accepted with the counter already at 1024, len_err SHALL set and stay set until reset or the next start; the frame still completes normally.
- Undefined: there SHALL be no counter, and len_err SHALL be tied to 0.

Verification
REQ-017 Reset then idle: outputs at the REQ-014 values; s_ready=0 for 20 cycles with s_valid=1.
REQ-018 pid=0x3, payload ASCII "123456789", m_ready=1 -> output sequence:
- 0xC3 (PID byte)
- 0x31 ... 0x39 (payload)
- crc_out = 0xAEE7
- 0x18, then 0x51 with m_last=1
REQ-019 zlp=1, pid=0xB -> output 0x4B, 0x00, 0x00 (m_last on the third byte); crc_out = 0xFFFF.
REQ-020 Same frame as REQ-018, with m_ready toggling pseudo-randomly and s_valid gaps -> identical byte sequence, no drops or duplicates, and m_* stable while stalled.
REQ-021 start pulsed during PAYLOAD -> ignored, current frame unaffected. Reset asserted at the 4th payload byte -> IDLE immediately; the following frame is correct.
REQ-022 With USB_TX_FRAMER_LEN_CHECK_EN defined, 1025-byte payload -> len_err rises on acceptance of the 1025th byte and the frame still closes with CRC. Without the macro -> len_err stays 0.
